// File: rtl/cla_sub_pipe_pkg.sv
// rtl/cla_sub_pipe_pkg.sv - shared lookahead defaults and result flag type for the CLA subtractor
package cla_sub_pipe_pkg;

    localparam int CLA_GROUP_DEFAULT = 4;

    typedef struct packed {
        logic borrow;
        logic ovf;
        logic zero;
    } cla_flags_t;

    function automatic int cla_ngroup(input int width, input int group);
        return width / group;
    endfunction

endpackage

// File: rtl/cla_sub_pipe_if.sv
// rtl/cla_sub_pipe_if.sv - operand/result valid-ready stream bundle for cla_sub_pipe
interface cla_sub_pipe_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, borrow, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, borrow, ovf, zero
    );
endinterface

// File: rtl/cla_sub_pipe_gp_group.sv
// rtl/cla_sub_pipe_gp_group.sv - GROUP-bit generate/propagate cell with in-group bit carries
module cla_gp_group #(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] i_a,
    input  logic [GROUP-1:0] i_nb,
    input  logic             i_c_in,
    output logic             o_gg,
    output logic             o_gp,
    output logic [GROUP-1:0] o_c
);
    logic [GROUP-1:0] w_g;
    logic [GROUP-1:0] w_p;
    logic [GROUP-1:0] w_c;
    logic             w_gg;

    // o_c[i] is the carry into bit i of the group
    always_comb begin
        w_g    = i_a & i_nb;
        w_p    = i_a | i_nb;
        w_c    = '0;
        w_c[0] = i_c_in;
        for (int i = 1; i < GROUP; i++) begin
            w_c[i] = w_g[i-1] | (w_p[i-1] & w_c[i-1]);
        end
        w_gg = 1'b0;
        for (int i = 0; i < GROUP; i++) begin
            w_gg = w_g[i] | (w_p[i] & w_gg);
        end
    end

    assign o_c  = w_c;
    assign o_gg = w_gg;
    assign o_gp = &w_p;
endmodule

// File: rtl/cla_sub_pipe.sv
// rtl/cla_sub_pipe.sv - 2-stage valid/ready carry-lookahead subtractor, diff = a - b - bin
// Optional: CLA_SUB_SAT_EN clamps diff to 0 on unsigned borrow.
module cla_sub_pipe
    import cla_sub_pipe_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GROUP = CLA_GROUP_DEFAULT
) (
    input logic           clk,
    input logic           rst,
    cla_sub_pipe_if.slave bus
);
    localparam int NGROUP = cla_ngroup(WIDTH, GROUP);

    generate
        if (WIDTH % GROUP != 0) begin : g_width_check
            $error("cla_sub_pipe: WIDTH must be a multiple of GROUP");
        end
    endgenerate

    logic              w_s1_en;
    logic              w_s2_en;
    logic              w_accept;
    logic [WIDTH-1:0]  w_nb;
    logic [NGROUP-1:0] w_gg;
    logic [NGROUP-1:0] w_gp;
    logic [WIDTH-1:0]  w_pg;

    logic              r_s1_valid;
    logic [WIDTH-1:0]  r_g;
    logic [WIDTH-1:0]  r_p;
    logic [WIDTH-1:0]  r_pg;
    logic [NGROUP-1:0] r_gg;
    logic [NGROUP-1:0] r_gp;
    logic              r_c0;
    logic              r_a_msb;
    logic              r_b_msb;

    logic              r_out_valid;
    logic [WIDTH-1:0]  r_diff;
    cla_flags_t        r_flags;

    assign w_s2_en      = ~r_out_valid | bus.out_ready;
    assign w_s1_en      = ~r_s1_valid | w_s2_en;
    assign w_accept     = bus.in_valid & w_s1_en;
    assign bus.in_ready = w_s1_en;
    assign w_nb         = ~bus.b;

    // Evaluated with carry-in 0, the cell's bit carries are the in-group prefix generates
    genvar k;
    generate
        for (k = 0; k < NGROUP; k++) begin : g_grp
            cla_gp_group #(.GROUP(GROUP)) u_grp (
                .i_a    (bus.a[k*GROUP +: GROUP]),
                .i_nb   (w_nb[k*GROUP +: GROUP]),
                .i_c_in (1'b0),
                .o_gg   (w_gg[k]),
                .o_gp   (w_gp[k]),
                .o_c    (w_pg[k*GROUP +: GROUP])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_g        <= '0;
            r_p        <= '0;
            r_pg       <= '0;
            r_gg       <= '0;
            r_gp       <= '0;
            r_c0       <= 1'b0;
            r_a_msb    <= 1'b0;
            r_b_msb    <= 1'b0;
        end else if (w_s1_en) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_g     <= bus.a & w_nb;
                r_p     <= bus.a | w_nb;
                r_pg    <= w_pg;
                r_gg    <= w_gg;
                r_gp    <= w_gp;
                r_c0    <= ~bus.bin;
                r_a_msb <= bus.a[WIDTH-1];
                r_b_msb <= bus.b[WIDTH-1];
            end
        end
    end

    logic [NGROUP:0]  w_cg;
    logic [WIDTH-1:0] w_c;
    logic             w_pp;
    logic             w_prev_p;
    logic [WIDTH-1:0] w_diff_raw;
    logic [WIDTH-1:0] w_diff_out;
    cla_flags_t       w_flags;

    always_comb begin
        w_cg     = '0;
        w_c      = '0;
        w_pp     = 1'b1;
        w_prev_p = 1'b0;
        w_cg[0]  = r_c0;
        for (int g = 0; g < NGROUP; g++) begin
            w_cg[g+1] = r_gg[g] | (r_gp[g] & w_cg[g]);
        end
        // bit carry = prefix generate | prefix propagate & group carry-in
        for (int i = 0; i < WIDTH; i++) begin
            w_pp     = (i % GROUP == 0) ? 1'b1 : (w_pp & w_prev_p);
            w_c[i]   = r_pg[i] | (w_pp & w_cg[i / GROUP]);
            w_prev_p = r_p[i];
        end
        w_diff_raw     = (r_p & ~r_g) ^ w_c;
        w_flags.borrow = ~w_cg[NGROUP];
        w_flags.ovf    = (r_a_msb ^ r_b_msb) & (w_diff_raw[WIDTH-1] ^ r_a_msb);
        w_flags.zero   = ~|w_diff_raw;
`ifdef CLA_SUB_SAT_EN
        w_diff_out     = w_flags.borrow ? '0 : w_diff_raw;
`else
        w_diff_out     = w_diff_raw;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_diff      <= '0;
            r_flags     <= '0;
        end else if (w_s2_en) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_diff  <= w_diff_out;
                r_flags <= w_flags;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.diff      = r_diff;
    assign bus.borrow    = r_flags.borrow;
    assign bus.ovf       = r_flags.ovf;
    assign bus.zero      = r_flags.zero;
endmodule

// File: tb/tb_cla_sub_pipe.sv
// tb/tb_cla_sub_pipe.sv - directed and random stream checks for cla_sub_pipe (WIDTH=16)
module tb_cla_sub_pipe;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

`ifdef CLA_SUB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    cla_sub_pipe_if #(.WIDTH(16)) bus ();

    cla_sub_pipe #(.WIDTH(16), .GROUP(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic bin);
        logic [16:0] full;
        logic [15:0] raw;
        logic        brw;
        logic        ovf;
        full = {1'b0, a} - {1'b0, b} - {16'b0, bin};
        raw  = full[15:0];
        brw  = full[16];
        ovf  = (a[15] != b[15]) && (raw[15] != a[15]);
        return {(SAT && brw) ? 16'h0000 : raw, brw, ovf, (raw == 16'h0000)};
    endfunction

    // One isolated beat: result must be absent one cycle after accept and present the next
    task automatic op(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic bin, input logic [15:0] raw, input logic brw,
                      input logic ovf, input logic zero);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a = a;
        bus.b = b;
        bus.bin = bin;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk({tag, "_early"}, 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_res"}, 32'({bus.diff, bus.borrow, bus.ovf, bus.zero}),
            32'({(SAT && brw) ? 16'h0000 : raw, brw, ovf, zero}));
    endtask

    logic [18:0] exp_q[$];
    logic [18:0] e;
    int sent;
    int rcvd;
    int cyc;

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.bin = 1'b0;
        bus.out_ready = 1'b1;

        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_outputs", 32'({bus.diff, bus.borrow, bus.ovf, bus.zero}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

        op("t1", 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
        op("t2", 16'h0003, 16'h0005, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b0);
        op("t3_ovf", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        op("t3_zero", 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        op("t4_ripple", 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        op("bnd_lo", 16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        op("bnd_hi", 16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0);

        // Back-pressure: three beats offered with out_ready low
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.a = 16'd10; bus.b = 16'd1; bus.bin = 1'b0;
        @(negedge clk);
        bus.a = 16'd20; bus.b = 16'd2;
        @(negedge clk);
        bus.a = 16'd30; bus.b = 16'd3;
        #1;
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_first", 32'(bus.diff), 32'h0009);
        repeat (3) @(negedge clk);
        chk("bp_hold_diff", 32'(bus.diff), 32'h0009);
        chk("bp_hold_ready", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("bp_second", 32'({bus.out_valid, bus.diff}), 32'h10012);
        @(negedge clk);
        chk("bp_third", 32'({bus.out_valid, bus.diff}), 32'h1001B);
        @(negedge clk);
        chk("bp_drained", 32'(bus.out_valid), 32'd0);

        // Reset with two beats in flight
        bus.in_valid = 1'b1;
        bus.a = 16'h0100; bus.b = 16'h0001;
        @(negedge clk);
        bus.a = 16'h0200;
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_outputs", 32'({bus.diff, bus.borrow, bus.ovf, bus.zero}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_no_beat", 32'(bus.out_valid), 32'd0);
        end

        // Random stream with random back-pressure
        sent = 0;
        rcvd = 0;
        cyc = 0;
        while (rcvd < 200 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (sent < 200) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                bus.a = 16'($urandom);
                bus.b = 16'($urandom);
                bus.bin = 1'($urandom_range(0, 1));
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rand_extra_beat", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rand_beat", 32'({bus.diff, bus.borrow, bus.ovf, bus.zero}), 32'(e));
                    rcvd++;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(bus.a, bus.b, bus.bin));
                sent++;
            end
        end
        chk("rand_count", 32'(rcvd), 32'd200);
        bus.in_valid = 1'b0;

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
